// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Also holds the register-match helper used by the hazard comparators.
package hazard_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam logic [4:0]  REG_ZERO       = 5'd0;
  localparam int unsigned MD_LAT_DEFAULT = 32;
  localparam int unsigned MD_CNT_W       = 8;

  // True when the ID instruction reads register r; $0 never matches.
  function automatic logic reg_match(input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rs,
                                     input logic       uses_rt,
                                     input logic [4:0] r);
    return (r != REG_ZERO) && ((uses_rs && (rs == r)) || (uses_rt && (rt == r)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle between the datapath stages and the hazard controller.
// The master side is the datapath, the slave side is the controller.
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);

  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_UsesRs;
  logic             ID_UsesRt;
  logic             ID_Branch;
  logic             ID_JumpReg;
  logic             ID_Taken;
  logic             ID_HiLoRead;
  logic             ID_MulDivStart;
  logic             EX_RegWrite;
  logic             EX_MemRead;
  logic [4:0]       EX_WriteReg;
  logic             MEM_MemRead;
  logic [4:0]       MEM_WriteReg;

  logic             PC_Ld;
  logic             IFID_Ld;
  logic             IFID_Flush;
  logic             IDEX_Bubble;
  logic             MD_Busy;
  logic             MD_Done;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_Branch, ID_JumpReg, ID_Taken,
           ID_HiLoRead, ID_MulDivStart, EX_RegWrite, EX_MemRead, EX_WriteReg,
           MEM_MemRead, MEM_WriteReg,
    input  PC_Ld, IFID_Ld, IFID_Flush, IDEX_Bubble, MD_Busy, MD_Done, StallCount
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_Branch, ID_JumpReg, ID_Taken,
           ID_HiLoRead, ID_MulDivStart, EX_RegWrite, EX_MemRead, EX_WriteReg,
           MEM_MemRead, MEM_WriteReg,
    output PC_Ld, IFID_Ld, IFID_Flush, IDEX_Bubble, MD_Busy, MD_Done, StallCount
  );

endinterface

// File: rtl/hazard_stall_ctrl_muldiv_sequencer.sv
// Occupancy tracker for the multi-cycle HI/LO multiply/divide unit.
// An accepted op produces MD_Done exactly MD_LAT cycles after acceptance.
module muldiv_sequencer
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LAT = MD_LAT_DEFAULT
) (
  input  logic      Clk,
  input  logic      Rst,
  input  logic      accept,
  output logic      MD_Busy,
  output logic      MD_Done,
  output md_state_t state
);

  if (MD_LAT < 2 || MD_LAT > 255) begin : g_bad_lat
    $error("muldiv_sequencer: MD_LAT must be in 2..255");
  end

  // One cycle is spent entering BUSY and one in DONE, hence the -2.
  localparam logic [MD_CNT_W-1:0] LoadVal = MD_CNT_W'(MD_LAT - 2);

  md_state_t           r_state;
  md_state_t           w_state_d;
  logic [MD_CNT_W-1:0] r_cnt;
  logic [MD_CNT_W-1:0] w_cnt_d;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      MD_IDLE: begin
        if (accept) begin
          w_state_d = MD_BUSY;
          w_cnt_d   = LoadVal;
        end
      end
      MD_BUSY: begin
        if (r_cnt == '0) begin
          w_state_d = MD_DONE;
        end else begin
          w_cnt_d = r_cnt - MD_CNT_W'(1);
        end
      end
      MD_DONE: w_state_d = MD_IDLE;
      default: w_state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Reset also masks the flags in the cycle it is asserted, so an abort never pulses Done.
  assign MD_Busy = ~Rst & (r_state != MD_IDLE);
  assign MD_Done = ~Rst & (r_state == MD_DONE);
  assign state   = r_state;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use, branch-in-ID and HI/LO hazards,
// PC / IF/ID enables, IF/ID flush, ID/EX bubble and a saturating stall counter.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LAT = MD_LAT_DEFAULT,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                Clk,
  input  logic                Rst,
  hazard_stall_ctrl_if.slave  bus
);

  logic       w_match_ex;
  logic       w_match_mem;
  logic       w_is_branch;
  logic       w_load_use;
  logic       w_branch_stall;
  logic       w_hilo_stall;
  logic       w_stall;
  logic       w_accept;
  logic       w_md_busy;
  logic       w_md_done;
  md_state_t  w_md_state;

  logic [CNT_W-1:0] r_stall_cnt;

  assign w_match_ex  = reg_match(bus.ID_Rs, bus.ID_Rt, bus.ID_UsesRs, bus.ID_UsesRt,
                                 bus.EX_WriteReg);
  assign w_match_mem = reg_match(bus.ID_Rs, bus.ID_Rt, bus.ID_UsesRs, bus.ID_UsesRt,
                                 bus.MEM_WriteReg);
  assign w_is_branch = bus.ID_Branch | bus.ID_JumpReg;

  assign w_load_use     = bus.EX_MemRead & w_match_ex;
  // Branches compare in ID, so any EX producer or a load still in MEM is too late to forward.
  assign w_branch_stall = w_is_branch & ((bus.EX_RegWrite & w_match_ex) |
                                         (bus.MEM_MemRead & w_match_mem));
  assign w_hilo_stall   = (bus.ID_HiLoRead | bus.ID_MulDivStart) & (w_md_state != MD_IDLE);
  assign w_stall        = w_load_use | w_branch_stall | w_hilo_stall;

  assign w_accept = bus.ID_MulDivStart & ~w_stall & ~Rst;

  muldiv_sequencer #(
    .MD_LAT (MD_LAT)
  ) u_muldiv_sequencer (
    .Clk     (Clk),
    .Rst     (Rst),
    .accept  (w_accept),
    .MD_Busy (w_md_busy),
    .MD_Done (w_md_done),
    .state   (w_md_state)
  );

  always_comb begin
    bus.PC_Ld       = 1'b1;
    bus.IFID_Ld     = 1'b1;
    bus.IFID_Flush  = 1'b0;
    bus.IDEX_Bubble = 1'b0;
    if (!Rst) begin
      bus.PC_Ld       = ~w_stall;
      bus.IFID_Ld     = ~w_stall;
      bus.IDEX_Bubble = w_stall;
      // A stalled branch is re-evaluated next cycle, so stall wins over the flush.
      bus.IFID_Flush  = bus.ID_Taken & ~w_stall;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.MD_Busy    = w_md_busy;
  assign bus.MD_Done    = w_md_done;
  assign bus.StallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with MD_LAT=4 and a 16-bit stall counter.
module tb_hazard_stall_ctrl;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 Clk = ~Clk;

  hazard_stall_ctrl_if #(.CNT_W(16)) bus ();

  hazard_stall_ctrl #(
    .MD_LAT (4),
    .CNT_W  (16)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ID_Rs = 5'd0;          bus.ID_Rt = 5'd0;
    bus.ID_UsesRs = 1'b0;      bus.ID_UsesRt = 1'b0;
    bus.ID_Branch = 1'b0;      bus.ID_JumpReg = 1'b0;
    bus.ID_Taken = 1'b0;       bus.ID_HiLoRead = 1'b0;
    bus.ID_MulDivStart = 1'b0; bus.EX_RegWrite = 1'b0;
    bus.EX_MemRead = 1'b0;     bus.EX_WriteReg = 5'd0;
    bus.MEM_MemRead = 1'b0;    bus.MEM_WriteReg = 5'd0;
  endtask

  task automatic ex_load(input logic [4:0] r);
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_WriteReg = r;
  endtask

  initial begin
    clear_inputs();
    // Reset overrides a live load-use hazard and a taken branch.
    step();
    ex_load(5'd8); bus.ID_UsesRs = 1'b1; bus.ID_Rs = 5'd8; bus.ID_Taken = 1'b1;
    #4;
    chk("rst_pc_ld", bus.PC_Ld, 1);
    chk("rst_ifid_ld", bus.IFID_Ld, 1);
    chk("rst_bubble", bus.IDEX_Bubble, 0);
    chk("rst_flush", bus.IFID_Flush, 0);
    chk("rst_md_busy", bus.MD_Busy, 0);
    chk("rst_md_done", bus.MD_Done, 0);
    step(); Rst = 1'b0; clear_inputs(); #4;
    chk("post_rst_cnt", bus.StallCount, 0);
    chk("post_rst_pc_ld", bus.PC_Ld, 1);

    // lw $8 in EX, add uses $8 in ID.
    step(); ex_load(5'd8); bus.ID_UsesRs = 1'b1; bus.ID_Rs = 5'd8; #4;
    chk("lu_pc_ld", bus.PC_Ld, 0);
    chk("lu_ifid_ld", bus.IFID_Ld, 0);
    chk("lu_bubble", bus.IDEX_Bubble, 1);
    chk("lu_flush", bus.IFID_Flush, 0);
    step(); bus.EX_MemRead = 1'b0; bus.EX_RegWrite = 1'b0; bus.EX_WriteReg = 5'd0;
    bus.MEM_MemRead = 1'b1; bus.MEM_WriteReg = 5'd8; #4;
    chk("lu_cnt", bus.StallCount, 1);
    chk("lu_resume_pc_ld", bus.PC_Ld, 1);
    chk("lu_resume_bubble", bus.IDEX_Bubble, 0);

    // beq on $8 behind lw $8: two stall cycles then flush.
    step(); clear_inputs(); ex_load(5'd8);
    bus.ID_Branch = 1'b1; bus.ID_Taken = 1'b1; bus.ID_UsesRs = 1'b1; bus.ID_Rs = 5'd8; #4;
    chk("br_ex_pc_ld", bus.PC_Ld, 0);
    chk("br_ex_flush", bus.IFID_Flush, 0);
    step(); bus.EX_MemRead = 1'b0; bus.EX_RegWrite = 1'b0; bus.EX_WriteReg = 5'd0;
    bus.MEM_MemRead = 1'b1; bus.MEM_WriteReg = 5'd8; #4;
    chk("br_mem_pc_ld", bus.PC_Ld, 0);
    chk("br_mem_bubble", bus.IDEX_Bubble, 1);
    chk("br_mem_flush", bus.IFID_Flush, 0);
    chk("br_mem_cnt", bus.StallCount, 2);
    step(); bus.MEM_MemRead = 1'b0; bus.MEM_WriteReg = 5'd0; #4;
    chk("br_go_pc_ld", bus.PC_Ld, 1);
    chk("br_go_flush", bus.IFID_Flush, 1);
    chk("br_go_bubble", bus.IDEX_Bubble, 0);
    chk("br_go_cnt", bus.StallCount, 3);

    // $0 never hazards.
    step(); clear_inputs(); ex_load(5'd0);
    bus.ID_UsesRs = 1'b1; bus.ID_Rs = 5'd0; bus.ID_Branch = 1'b1; #4;
    chk("zero_pc_ld", bus.PC_Ld, 1);
    chk("zero_bubble", bus.IDEX_Bubble, 0);

    // rt match only counts when rt is used.
    step(); clear_inputs(); ex_load(5'd9); bus.ID_Rt = 5'd9; #4;
    chk("rt_unused_pc_ld", bus.PC_Ld, 1);
    bus.ID_UsesRt = 1'b1; #1;
    chk("rt_used_pc_ld", bus.PC_Ld, 0);

    // ALU producer in EX stalls jr but not an ordinary consumer.
    step(); clear_inputs(); bus.EX_RegWrite = 1'b1; bus.EX_WriteReg = 5'd5;
    bus.ID_UsesRs = 1'b1; bus.ID_Rs = 5'd5; #4;
    chk("alu_add_pc_ld", bus.PC_Ld, 1);
    chk("rt_cnt", bus.StallCount, 4);
    bus.ID_JumpReg = 1'b1; #1;
    chk("alu_jr_pc_ld", bus.PC_Ld, 0);

    // mult at cycle 0, mfhi at cycle 2.
    step(); clear_inputs(); bus.ID_MulDivStart = 1'b1; #4;
    chk("md_c0_pc_ld", bus.PC_Ld, 1);
    chk("md_c0_busy", bus.MD_Busy, 0);
    chk("md_c0_cnt", bus.StallCount, 5);
    step(); clear_inputs(); #4;
    chk("md_c1_busy", bus.MD_Busy, 1);
    chk("md_c1_done", bus.MD_Done, 0);
    step(); bus.ID_HiLoRead = 1'b1; #4;
    chk("md_c2_pc_ld", bus.PC_Ld, 0);
    chk("md_c2_busy", bus.MD_Busy, 1);
    step(); #4;
    chk("md_c3_pc_ld", bus.PC_Ld, 0);
    chk("md_c3_done", bus.MD_Done, 0);
    step(); #4;
    chk("md_c4_done", bus.MD_Done, 1);
    chk("md_c4_busy", bus.MD_Busy, 1);
    chk("md_c4_pc_ld", bus.PC_Ld, 0);
    step(); #4;
    chk("md_c5_busy", bus.MD_Busy, 0);
    chk("md_c5_done", bus.MD_Done, 0);
    chk("md_c5_pc_ld", bus.PC_Ld, 1);
    chk("md_c5_cnt", bus.StallCount, 8);

    // Second op arriving in DONE waits one cycle.
    step(); clear_inputs(); bus.ID_MulDivStart = 1'b1; #4;
    chk("b2b_c0_pc_ld", bus.PC_Ld, 1);
    step(); clear_inputs();
    step();
    step();
    step(); bus.ID_MulDivStart = 1'b1; #4;
    chk("b2b_c4_done", bus.MD_Done, 1);
    chk("b2b_c4_pc_ld", bus.PC_Ld, 0);
    step(); #4;
    chk("b2b_c5_busy", bus.MD_Busy, 0);
    chk("b2b_c5_pc_ld", bus.PC_Ld, 1);
    chk("b2b_c5_cnt", bus.StallCount, 9);
    step(); clear_inputs(); #4;
    chk("b2b_c6_busy", bus.MD_Busy, 1);

    // Reset in the middle of BUSY aborts the op.
    step(); Rst = 1'b1; #4;
    chk("abort_rst_busy", bus.MD_Busy, 0);
    chk("abort_rst_pc_ld", bus.PC_Ld, 1);
    step(); Rst = 1'b0; #4;
    chk("abort_busy", bus.MD_Busy, 0);
    chk("abort_done", bus.MD_Done, 0);
    chk("abort_cnt", bus.StallCount, 0);
    for (int i = 0; i < 4; i++) begin
      step(); #4;
      chk("abort_no_done", bus.MD_Done, 0);
      chk("abort_no_busy", bus.MD_Busy, 0);
    end

    // Saturation of the stall counter.
    step(); ex_load(5'd8); bus.ID_UsesRs = 1'b1; bus.ID_Rs = 5'd8;
    repeat (65534) step();
    #4;
    chk("sat_fffe", bus.StallCount, 32'h0000_FFFE);
    repeat (5) step();
    #4;
    chk("sat_ffff", bus.StallCount, 32'h0000_FFFF);
    chk("sat_pc_ld", bus.PC_Ld, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
